// File: rtl/dsp_pkg.sv
// Shared DSP types: DDS control write payload and the command-stream header
// parsed by dds_control_writer.
package dsp_pkg;

    localparam int unsigned DDS_NUM_CHANNELS                     = 16;
    localparam int unsigned DDS_CHANNEL_INDEX_WIDTH              = $clog2(DDS_NUM_CHANNELS);
    localparam int unsigned DDS_CONTROL_ENTRY_PACKED_WIDTH       = 48;
    localparam int unsigned DDS_CONTROL_SETUP_ENTRY_PACKED_WIDTH = 4;

    typedef enum logic [1:0] {
        DDS_CTRL_NONE      = 2'd0,
        DDS_CTRL_LFSR      = 2'd1,
        DDS_CTRL_SIN_SWEEP = 2'd2,
        DDS_CTRL_SIN_STEP  = 2'd3
    } dds_control_type_e;

    typedef struct packed {
        logic       phase_reset;
        logic [2:0] gain_shift;
    } dds_control_setup_entry_t;

    typedef struct packed {
        logic                                      valid;
        logic [DDS_CHANNEL_INDEX_WIDTH-1:0]        channel_index;
        dds_control_setup_entry_t                  setup;
        dds_control_type_e                         control_type;
        logic [DDS_CONTROL_ENTRY_PACKED_WIDTH-1:0] control_data;
    } dds_control_t;

    localparam logic [7:0]  DDS_CONTROL_WRITER_MAGIC = 8'hD5;
    localparam int unsigned DDS_CONTROL_TYPE_MAX     = 3;
    localparam int unsigned DDS_CONTROL_WRITER_WORDS = (DDS_CONTROL_ENTRY_PACKED_WIDTH + 31) / 32;

    typedef struct packed {
        logic [7:0] magic;
        logic [7:0] setup;
        logic [3:0] reserved;
        logic [3:0] control_type;
        logic [7:0] channel_index;
    } dds_control_writer_header_t;

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DRAIN   = 2'd2,
        S_ISSUE   = 2'd3
    } dds_control_writer_state_e;

endpackage

// File: rtl/dds_control_writer.sv
// Parses header + payload word frames into single-cycle dds_control_t writes;
// malformed frames are drained and counted, never partially written.
module dds_control_writer
    import dsp_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS        = DDS_NUM_CHANNELS,
    parameter int unsigned CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int unsigned CONTROL_WORDS       = DDS_CONTROL_WRITER_WORDS
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Input_valid,
    input  logic         Input_last,
    input  logic [31:0]  Input_data,
    output logic         Input_ready,
    output dds_control_t Control_data,
    output logic [15:0]  Error_count,
    output logic [15:0]  Frame_count
);

    localparam int unsigned     WORD_W    = 32;
    localparam int unsigned     K_W       = (CONTROL_WORDS > 1) ? $clog2(CONTROL_WORDS) : 1;
    localparam int unsigned     PAYLOAD_W = CONTROL_WORDS * WORD_W;
    localparam logic [K_W-1:0]  K_LAST    = K_W'(CONTROL_WORDS - 1);
    localparam logic [15:0]     COUNT_MAX = 16'hFFFF;

    dds_control_writer_state_e            state_q, state_d;
    logic [K_W-1:0]                       k_q, k_d;
    logic [CHANNEL_INDEX_WIDTH-1:0]       chan_q, chan_d;
    dds_control_setup_entry_t             setup_q, setup_d;
    dds_control_type_e                    type_q, type_d;
    logic [CONTROL_WORDS-1:0][WORD_W-1:0] payload_q, payload_d;
    dds_control_t                         ctrl_q, ctrl_d;
    logic                                 ready_q, ready_d;
    logic [15:0]                          err_q, err_d;
    logic [15:0]                          frame_q, frame_d;

    logic                       accept;
    logic                       hdr_ok;
    logic                       err_bump;
    dds_control_writer_header_t hdr;
    logic [PAYLOAD_W-1:0]       payload_flat;
    logic                       unused_hdr_bits;

    assign accept       = Input_valid && ready_q;
    assign hdr          = dds_control_writer_header_t'(Input_data);
    assign payload_flat = payload_q;
    assign hdr_ok       = (hdr.magic == DDS_CONTROL_WRITER_MAGIC)
                       && (32'(hdr.control_type) <= DDS_CONTROL_TYPE_MAX)
                       && (32'(hdr.channel_index) < NUM_CHANNELS);

    // Reserved nibble and setup bits above the entry width are don't-care.
    assign unused_hdr_bits = ^{hdr.reserved, hdr.setup[7:DDS_CONTROL_SETUP_ENTRY_PACKED_WIDTH]};

    // Next-state, datapath and counter updates.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        chan_d       = chan_q;
        setup_d      = setup_q;
        type_d       = type_q;
        payload_d    = payload_q;
        ctrl_d       = ctrl_q;
        ctrl_d.valid = 1'b0;
        frame_d      = frame_q;
        err_d        = err_q;
        err_bump     = 1'b0;

        case (state_q)
            S_HEADER: begin
                if (accept) begin
                    if (hdr_ok && !Input_last) begin
                        chan_d  = CHANNEL_INDEX_WIDTH'(hdr.channel_index);
                        setup_d = dds_control_setup_entry_t'(hdr.setup[DDS_CONTROL_SETUP_ENTRY_PACKED_WIDTH-1:0]);
                        type_d  = dds_control_type_e'(hdr.control_type[1:0]);
                        k_d     = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        err_bump = 1'b1;
                        state_d  = Input_last ? S_HEADER : S_DRAIN;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    payload_d[k_q] = Input_data;
                    if (k_q == K_LAST) begin
                        if (Input_last) begin
                            state_d = S_ISSUE;
                        end else begin
                            err_bump = 1'b1;
                            state_d  = S_DRAIN;
                        end
                    end else if (Input_last) begin
                        err_bump = 1'b1;
                        state_d  = S_HEADER;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && Input_last) begin
                    state_d = S_HEADER;
                end
            end
            S_ISSUE: begin
                ctrl_d.valid         = 1'b1;
                ctrl_d.channel_index = DDS_CHANNEL_INDEX_WIDTH'(chan_q);
                ctrl_d.setup         = setup_q;
                ctrl_d.control_type  = type_q;
                ctrl_d.control_data  = DDS_CONTROL_ENTRY_PACKED_WIDTH'(payload_flat);
                frame_d              = frame_q + 16'd1;
                state_d              = S_HEADER;
            end
            default: begin
                state_d = S_HEADER;
            end
        endcase

        if (err_bump && (err_q != COUNT_MAX)) begin
            err_d = err_q + 16'd1;
        end

        ready_d = (state_d != S_ISSUE);
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_HEADER;
            k_q       <= '0;
            chan_q    <= '0;
            setup_q   <= '0;
            type_q    <= DDS_CTRL_NONE;
            payload_q <= '0;
            ctrl_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= '0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            chan_q    <= chan_d;
            setup_q   <= setup_d;
            type_q    <= type_d;
            payload_q <= payload_d;
            ctrl_q    <= ctrl_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            frame_q   <= frame_d;
        end
    end

    assign Input_ready  = ready_q;
    assign Control_data = ctrl_q;
    assign Error_count  = err_q;
    assign Frame_count  = frame_q;

endmodule

// File: tb/tb_dds_control_writer.sv
// Bench for dds_control_writer: directed and randomized frames checked
// against a per-frame expectation model and write scoreboard.
module tb_dds_control_writer;
    import dsp_pkg::*;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Input_valid;
    logic         Input_last;
    logic [31:0]  Input_data;
    logic         Input_ready;
    dds_control_t Control_data;
    logic [15:0]  Error_count;
    logic [15:0]  Frame_count;

    dds_control_writer dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Input_valid  (Input_valid),
        .Input_last   (Input_last),
        .Input_data   (Input_data),
        .Input_ready  (Input_ready),
        .Control_data (Control_data),
        .Error_count  (Error_count),
        .Frame_count  (Frame_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int           cyc;
        dds_control_t c;
    } obs_t;

    int           checks = 0;
    int           errors = 0;
    int           cycle = 0;
    int           ready_low = 0;
    int           exp_err = 0;
    int           exp_frames = 0;
    obs_t         obs_q[$];
    dds_control_t exp_q[$];

    always @(posedge Clk) cycle <= cycle + 1;

    always @(negedge Clk) begin
        if (Control_data.valid) obs_q.push_back('{cycle, Control_data});
        if (!Input_ready && !Rst) ready_low++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_hdr(input logic [7:0] magic, input logic [7:0] setup,
                                           input logic [3:0] rsv, input logic [3:0] typ,
                                           input logic [7:0] ch);
        return {magic, setup, rsv, typ, ch};
    endfunction

    // One beat, presented at a negedge; returns at the negedge after acceptance.
    task automatic send_beat(input logic [31:0] d, input logic l, input int gap);
        int guard;
        if (gap > 0) begin
            Input_valid = 1'b0;
            repeat (gap) @(negedge Clk);
        end
        Input_valid = 1'b1;
        Input_data  = d;
        Input_last  = l;
        guard = 0;
        while (!Input_ready && guard < 50) begin
            @(negedge Clk);
            guard++;
        end
        if (!Input_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: Input_ready=0 after %0d cycles, required 1", guard);
        end else begin
            @(negedge Clk);
        end
        Input_valid = 1'b0;
        Input_last  = 1'b0;
    endtask

    task automatic send_tail(input int n, input int gmax);
        for (int i = 0; i < n; i++) send_beat($urandom, (i == n - 1), $urandom_range(0, gmax));
    endtask

    task automatic send_good(input logic [7:0] ch, input logic [3:0] typ, input logic [7:0] setup,
                             input int gmax);
        logic [31:0]  p0, p1;
        logic [63:0]  w;
        dds_control_t e;
        p0 = $urandom;
        p1 = $urandom;
        send_beat(mk_hdr(DDS_CONTROL_WRITER_MAGIC, setup, 4'($urandom), typ, ch), 1'b0, $urandom_range(0, gmax));
        send_beat(p0, 1'b0, $urandom_range(0, gmax));
        send_beat(p1, 1'b1, $urandom_range(0, gmax));
        w                = {p1, p0};
        e.valid          = 1'b1;
        e.channel_index  = ch[3:0];
        e.setup          = dds_control_setup_entry_t'(setup[3:0]);
        e.control_type   = dds_control_type_e'(typ[1:0]);
        e.control_data   = w[47:0];
        exp_q.push_back(e);
        exp_frames++;
    endtask

    // Malformed frame kinds: 1 magic, 2 channel, 3 type, 4 header-last, 5 short, 6 long.
    task automatic send_bad(input int kind, input int gmax);
        logic [7:0] magic;
        case (kind)
            1: begin
                do magic = 8'($urandom); while (magic == DDS_CONTROL_WRITER_MAGIC);
                send_beat(mk_hdr(magic, 8'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), 8'($urandom_range(0, 15))), 1'b0, gmax);
                send_tail($urandom_range(1, 3), gmax);
            end
            2: begin
                send_beat(mk_hdr(8'hD5, 8'($urandom), 4'h0, 4'($urandom_range(0, 3)), 8'($urandom_range(16, 255))), 1'b0, gmax);
                send_tail($urandom_range(1, 3), gmax);
            end
            3: begin
                send_beat(mk_hdr(8'hD5, 8'($urandom), 4'h0, 4'($urandom_range(4, 15)), 8'($urandom_range(0, 15))), 1'b0, gmax);
                send_tail($urandom_range(1, 3), gmax);
            end
            4: send_beat(mk_hdr(8'hD5, 8'h00, 4'h0, 4'd1, 8'($urandom_range(0, 15))), 1'b1, gmax);
            5: begin
                send_beat(mk_hdr(8'hD5, 8'h00, 4'h0, 4'd1, 8'($urandom_range(0, 15))), 1'b0, gmax);
                send_beat($urandom, 1'b1, gmax);
            end
            default: begin
                send_beat(mk_hdr(8'hD5, 8'h00, 4'h0, 4'd3, 8'($urandom_range(0, 15))), 1'b0, gmax);
                send_beat($urandom, 1'b0, gmax);
                send_beat($urandom, 1'b0, gmax);
                send_tail($urandom_range(1, 3), gmax);
            end
        endcase
        if (exp_err < 65535) exp_err++;
    endtask

    task automatic check_scoreboard(input string tag);
        dds_control_t e;
        obs_t         o;
        repeat (3) @(negedge Clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL %s_write: no write observed, required %h", tag, e);
            end else begin
                o = obs_q.pop_front();
                if (o.c !== e) begin
                    errors++;
                    $display("FAIL %s_write: got %h required %h", tag, o.c, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s_extra: %0d unexpected writes, required 0", tag, obs_q.size());
        end
        obs_q.delete();
        checks++;
        if (Error_count !== exp_err[15:0]) begin
            errors++;
            $display("FAIL %s_error_count: got %0d required %0d", tag, Error_count, exp_err);
        end
        checks++;
        if (Frame_count !== exp_frames[15:0]) begin
            errors++;
            $display("FAIL %s_frame_count: got %0d required %0d", tag, Frame_count, exp_frames[15:0]);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Input_valid = 1'b0;
        Input_last = 1'b0;
        Input_data = '0;
        repeat (3) @(negedge Clk);
        checks++;
        if (Input_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", Input_ready); end
        checks++;
        if (Control_data !== '0) begin errors++; $display("FAIL reset_control: got %h required 0", Control_data); end
        checks++;
        if (Error_count !== 16'd0) begin errors++; $display("FAIL reset_error_count: got %0d required 0", Error_count); end
        checks++;
        if (Frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d required 0", Frame_count); end
        Rst = 1'b0;
        exp_err = 0;
        exp_frames = 0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_sweep();
        send_beat(32'hD502_0200, 1'b0, 0);
        send_beat(32'h7FFF_8001, 1'b0, 0);
        send_beat(32'h0000_000A, 1'b1, 0);
        checks++;
        if (Control_data.valid !== 1'b0) begin errors++; $display("FAIL sweep_early_valid: got %b required 0", Control_data.valid); end
        checks++;
        if (Input_ready !== 1'b0) begin errors++; $display("FAIL sweep_issue_ready: got %b required 0", Input_ready); end
        @(negedge Clk);
        checks++;
        if (Control_data.valid !== 1'b1) begin errors++; $display("FAIL sweep_valid: got %b required 1", Control_data.valid); end
        checks++;
        if (Control_data.channel_index !== 4'd0 || 4'(Control_data.setup) !== 4'd2 ||
            Control_data.control_type !== DDS_CTRL_SIN_SWEEP) begin
            errors++;
            $display("FAIL sweep_fields: got ch=%0d setup=%0d type=%0d required ch=0 setup=2 type=2",
                     Control_data.channel_index, 4'(Control_data.setup), Control_data.control_type);
        end
        checks++;
        if (Control_data.control_data !== 48'h000A_7FFF_8001) begin
            errors++; $display("FAIL sweep_data: got %h required 000a7fff8001", Control_data.control_data);
        end
        checks++;
        if (Frame_count !== 16'd1) begin errors++; $display("FAIL sweep_frame_count: got %0d required 1", Frame_count); end
        @(negedge Clk);
        checks++;
        if (Control_data.valid !== 1'b0 || Control_data.control_data !== 48'h000A_7FFF_8001) begin
            errors++; $display("FAIL sweep_hold: got valid=%b data=%h required valid=0 data=000a7fff8001",
                               Control_data.valid, Control_data.control_data);
        end
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL sweep_pulses: got %0d required 1", obs_q.size()); end
        obs_q.delete();
        exp_frames = 1;
    endtask

    task automatic test_back_to_back();
        ready_low = 0;
        for (int ch = 0; ch < 16; ch++) send_good(8'(ch), 4'd0, 8'($urandom), 0);
        repeat (2) @(negedge Clk);
        checks++;
        if (obs_q.size() != 16) begin
            errors++; $display("FAIL b2b_count: got %0d required 16", obs_q.size());
        end else begin
            for (int i = 1; i < 16; i++) begin
                checks++;
                if (obs_q[i].cyc - obs_q[i-1].cyc != 4) begin
                    errors++; $display("FAIL b2b_spacing: frame %0d gap %0d required 4", i, obs_q[i].cyc - obs_q[i-1].cyc);
                end
            end
        end
        checks++;
        if (ready_low != 16) begin errors++; $display("FAIL b2b_ready_low: got %0d cycles required 16", ready_low); end
        check_scoreboard("b2b");
    endtask

    task automatic test_bad_frames();
        send_beat(32'hAA00_0000, 1'b0, 0);
        exp_err++;
        checks++;
        if (Error_count !== exp_err[15:0]) begin
            errors++; $display("FAIL bad_magic_detect: got %0d required %0d", Error_count, exp_err);
        end
        send_tail(2, 0);
        send_good(8'd3, 4'd1, 8'h05, 0);
        check_scoreboard("bad_magic");
        send_beat(mk_hdr(8'hD5, 8'h00, 4'h0, 4'd1, 8'd16), 1'b0, 0);
        send_tail(2, 0);
        exp_err++;
        send_beat(mk_hdr(8'hD5, 8'h00, 4'h0, 4'd5, 8'd2), 1'b0, 0);
        send_tail(2, 0);
        exp_err++;
        send_bad(5, 0);
        send_good(8'd15, 4'd3, 8'hFF, 0);
        check_scoreboard("bad_hdr_short");
        send_beat(mk_hdr(8'hD5, 8'h00, 4'h0, 4'd2, 8'd7), 1'b0, 0);
        send_beat(32'h1234_5678, 1'b0, 0);
        send_beat(32'h9ABC_DEF0, 1'b0, 0);
        exp_err++;
        checks++;
        if (Error_count !== exp_err[15:0]) begin
            errors++; $display("FAIL long_detect: got %0d required %0d", Error_count, exp_err);
        end
        send_tail(3, 0);
        send_bad(4, 0);
        send_good(8'd9, 4'd2, 8'h1A, 1);
        check_scoreboard("bad_long");
    endtask

    task automatic test_random();
        int kind;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) send_good(8'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 8'($urandom), 2);
            else send_bad(kind - 3, 2);
        end
        check_scoreboard("random");
    endtask

    task automatic test_reset_mid();
        send_beat(mk_hdr(8'hD5, 8'h01, 4'h0, 4'd3, 8'd4), 1'b0, 0);
        send_beat(32'hCAFE_F00D, 1'b0, 0);
        #2 Rst = 1'b1;
        #1;
        checks++;
        if (Control_data !== '0) begin errors++; $display("FAIL midreset_control: got %h required 0", Control_data); end
        checks++;
        if (Error_count !== 16'd0 || Frame_count !== 16'd0) begin
            errors++; $display("FAIL midreset_counts: got err=%0d frames=%0d required 0 0", Error_count, Frame_count);
        end
        checks++;
        if (Input_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b required 0", Input_ready); end
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        exp_err = 0;
        exp_frames = 0;
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_pulse: got %0d writes required 0", obs_q.size()); end
        send_good(8'd11, 4'd1, 8'h03, 0);
        check_scoreboard("post_reset");
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_back_to_back();
        test_bad_frames();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
